// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen_frac
// Purpose  : Runtime-programmable fractional divider producing oversample,
//            bit-boundary and mid-bit ticks for UART TX/RX engines.
// Revision : 1.0 - initial release
// ============================================================================
module baud_gen_frac #(
  parameter int unsigned CLOCK        = 100000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_INT_W    = 16,
  parameter int unsigned DIV_FRAC_W   = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_restart,
  input  logic [DIV_INT_W-1:0]          i_div_int,
  input  logic [DIV_FRAC_W-1:0]         i_div_frac,
  input  logic                          i_div_load,
  output logic                          o_div_ack,
  output logic                          o_div_err,
  output logic                          o_tick_os,
  output logic                          o_tick_bit,
  output logic                          o_tick_mid,
  output logic [$clog2(OVERSAMPLE)-1:0] o_os_index
);

  localparam int unsigned c_IDX_W = $clog2(OVERSAMPLE);

  // Default divisor in Q(DIV_FRAC_W), rounded to nearest.
  localparam logic [63:0] c_DEN   = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
  localparam logic [63:0] c_DEF_Q = ((64'(CLOCK) << DIV_FRAC_W) + (c_DEN >> 1)) / c_DEN;

  localparam logic [DIV_INT_W-1:0]  c_DEF_INT  = DIV_INT_W'(c_DEF_Q >> DIV_FRAC_W);
  localparam logic [DIV_FRAC_W-1:0] c_DEF_FRAC = DIV_FRAC_W'(c_DEF_Q);
  localparam logic [DIV_INT_W-1:0]  c_INT_ONE  = DIV_INT_W'(1);
  localparam logic [DIV_INT_W-1:0]  c_INT_MIN  = DIV_INT_W'(2);
  localparam logic [c_IDX_W-1:0]    c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(OVERSAMPLE - 1);
  localparam logic [c_IDX_W-1:0]    c_IDX_MID  = c_IDX_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_INT_W-1:0]  cnt_q,       cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q,       acc_d;
  logic [c_IDX_W-1:0]    idx_q,       idx_d;
  logic [DIV_INT_W-1:0]  act_int_q,   act_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q,  act_frac_d;
  logic [DIV_INT_W-1:0]  pend_int_q,  pend_int_d;
  logic [DIV_FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic                  pend_vld_q,  pend_vld_d;
  logic                  ack_q,       ack_d;
  logic                  err_q,       err_d;

  logic                  w_tick;
  logic                  w_idle;
  logic                  w_apply;
  logic                  w_load_ok;
  logic                  w_load_bad;
  logic [DIV_INT_W-1:0]  w_eff_int;
  logic [DIV_FRAC_W-1:0] w_eff_frac;
  logic [DIV_FRAC_W:0]   w_sum;
  logic [DIV_INT_W-1:0]  w_carry;

  // cnt never reaches zero while idle because every reload is div_int-1 >= 1.
  assign w_tick     = (cnt_q == '0);
  assign w_idle     = !i_enable || i_restart;
  assign w_load_ok  = i_div_load && (i_div_int >= c_INT_MIN);
  assign w_load_bad = i_div_load && (i_div_int <  c_INT_MIN);
  assign w_apply    = pend_vld_q && (w_idle || w_tick);

  // The reload on the application cycle already uses the new divisor.
  assign w_eff_int  = w_apply ? pend_int_q  : act_int_q;
  assign w_eff_frac = w_apply ? pend_frac_q : act_frac_q;
  assign w_sum      = {1'b0, acc_q} + {1'b0, w_eff_frac};
  assign w_carry    = {{(DIV_INT_W-1){1'b0}}, w_sum[DIV_FRAC_W]};

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    idx_d = idx_q;
    if (w_idle) begin
      cnt_d = w_eff_int - c_INT_ONE;
      acc_d = '0;
      idx_d = '0;
    end else if (w_tick) begin
      cnt_d = w_eff_int - c_INT_ONE + w_carry;
      acc_d = w_sum[DIV_FRAC_W-1:0];
      idx_d = idx_q + c_IDX_ONE;
    end else begin
      cnt_d = cnt_q - c_INT_ONE;
    end
  end

  // A load arriving with an application captures the newer value as pending.
  always_comb begin
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_vld_d  = pend_vld_q;
    if (w_apply) begin
      act_int_d  = pend_int_q;
      act_frac_d = pend_frac_q;
      pend_vld_d = 1'b0;
    end
    if (w_load_ok) begin
      pend_int_d  = i_div_int;
      pend_frac_d = i_div_frac;
      pend_vld_d  = 1'b1;
    end
  end

  assign ack_d = w_apply;
  assign err_d = w_load_bad;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q       <= c_DEF_INT - c_INT_ONE;
      acc_q       <= '0;
      idx_q       <= '0;
      act_int_q   <= c_DEF_INT;
      act_frac_q  <= c_DEF_FRAC;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_vld_q  <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_vld_q  <= pend_vld_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign o_tick_os  = w_tick;
  assign o_tick_bit = w_tick && (idx_q == c_IDX_LAST);
  assign o_tick_mid = w_tick && (idx_q == c_IDX_MID);
  assign o_os_index = idx_q;
  assign o_div_ack  = ack_q;
  assign o_div_err  = err_q;

endmodule
`default_nettype wire
